fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline control block that generates the 1-bit `Src` select inputs for the 32-bit 2:1 operand muxes in the EX stage, plus the load-use stall.
- Each EX operand path is two cascaded 2:1 muxes:
  - forward mux: register-file value vs forwarded value.
  - source mux: WB value vs MEM value.
- Keeps a shadow record of destination registers in flight (EX, MEM) and registers the selects, so they are valid when the ID instruction enters EX.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..3).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_AW  source A register of the ID instruction.
- id_rt  input  REG_AW  source B register of the ID instruction.
- id_rs_used  input  1  the instruction reads rs.
- id_rt_used  input  1  the instruction reads rt.
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_wen  input  1  the instruction writes rd.
- id_is_load  input  1  the instruction is a load.
- flush  input  1  squash the ID instruction (branch taken).
- stall  output  1  hold PC and the IF/ID register this cycle.
- a_fwd  output  1  Src for operand A forward mux (1 = forwarded value).
- a_from_mem  output  1  Src for operand A source mux (1 = MEM, 0 = WB).
- b_fwd  output  1  same as a_fwd, for operand B.
- b_from_mem  output  1  same as a_from_mem, for operand B.
- stall_count  output  CNT_W  total cycles with stall=1.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all shadow valids = 0; stall counter cnt = 0.
  - a_fwd, a_from_mem, b_fwd, b_from_mem = 0; stall_count = 0.
  - stall reads 0 during the reset cycle.
  - A reset mid-stall drops the stall from the next cycle.
- Shadow stages hold {valid, rd, wen, load} for EX and {valid, rd, wen} for MEM.
  - Every cycle: MEM <= EX.
  - EX <= ID fields with valid = id_valid & ~flush & ~stall. A stall or flush therefore inserts a bubble.
- Match condition, per operand X in {rs, rt}, against stage S:
  - X_used & (X != 0) & S.valid & S.wen & (S.rd == X).
  - Register 0 never matches.
- Load-use detect:
  - id_valid & ~flush & (rs or rt matches EX) & EX.load.
  - Combinational stall = (cnt != 0) | (detect & cnt == 0).
  - When detect fires with cnt == 0: cnt <= LOAD_STALL-1.
  - While cnt != 0: cnt decrements by 1 per cycle.
  - flush clears cnt to 0 and suppresses detect in the same cycle.
- Select registers update every cycle:
  - If stall, flush or ~id_valid: all four selects <= 0 (the EX bubble uses register-file paths).
  - Otherwise, per operand:
    - Match EX (and not a stalling load): fwd <= 1, from_mem <= 1. The producer will be in MEM.
    - Else match MEM: fwd <= 1, from_mem <= 0. The producer will be in WB.
    - Else: both <= 0.
  - EX match takes priority over MEM match (youngest producer wins).
- After a load stall with LOAD_STALL=1:
  - the load is in MEM when ID is rechecked, so the result is forward from WB (from_mem = 0).
  - With LOAD_STALL >= 2 the load has left the shadow; the register file supplies the value and the selects are 0.
- WB-stage producers are not tracked; the register file writes before it reads.
- stall_count increments by 1 on each cycle with stall=1 and rst_n=1. It wraps modulo 2^CNT_W.
- Latency:
  - selects: 1 cycle (registered).
  - stall: 0 cycles (combinational from inputs and state).
- Simultaneous flush and load-use: flush wins; no stall; bubble enters EX.

Test Plan:
- Hold rst_n=0 for 2 cycles, then drive random inputs with rst_n=0 -> all outputs stay 0; stall_count=0.
- ALU writes rd=5; next instruction reads rs=5 -> next cycle a_fwd=1, a_from_mem=1, b_fwd=0; stall=0.
- rd=5 writer, then an unrelated instruction, then an instruction reading rt=5 -> b_fwd=1, b_from_mem=0.
- Two consecutive writers of r7, then a reader of rs=7 -> a_from_mem=1 (EX wins over MEM).
- Load to r9 followed by a reader of rt=9, LOAD_STALL=1 -> stall=1 for exactly 1 cycle; next cycle b_fwd=1, b_from_mem=0; stall_count=1. With LOAD_STALL=3 -> 3 stall cycles; selects 0; stall_count=3.
- Writer of r0 then a reader of rs=0 -> a_fwd=0. Load-use coinciding with flush=1 -> stall=0; selects 0; stall_count unchanged.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Brief    : EX-stage operand forwarding selects and load-use stall control.
//  Revision : 1.0
// ============================================================================

module fwd_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              a_fwd,
    output logic              a_from_mem,
    output logic              b_fwd,
    output logic              b_from_mem,
    output logic [CNT_W-1:0]  stall_count
);

    // Bubble counter holds at most LOAD_STALL-1 = 2 extra cycles.
    localparam int         c_cnt_w  = 2;
    localparam logic [1:0] c_reload = c_cnt_w'(LOAD_STALL - 1);

    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_wen;
    logic              r_ex_load;
    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_wen;
    logic [1:0]        r_cnt;

    logic              r_a_fwd;
    logic              r_a_from_mem;
    logic              r_b_fwd;
    logic              r_b_from_mem;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_id_live;
    logic w_a_ex;
    logic w_a_mem;
    logic w_b_ex;
    logic w_b_mem;
    logic w_detect;
    logic w_stall;
    logic w_a_fwd_nxt;
    logic w_a_mem_nxt;
    logic w_b_fwd_nxt;
    logic w_b_mem_nxt;

    function automatic logic f_match(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              s_valid,
        input logic              s_wen,
        input logic [REG_AW-1:0] s_rd
    );
        return used & (src != '0) & s_valid & s_wen & (s_rd == src);
    endfunction

    assign w_id_live = id_valid & ~flush;

    assign w_a_ex  = f_match(id_rs_used, id_rs, r_ex_valid,  r_ex_wen,  r_ex_rd);
    assign w_a_mem = f_match(id_rs_used, id_rs, r_mem_valid, r_mem_wen, r_mem_rd);
    assign w_b_ex  = f_match(id_rt_used, id_rt, r_ex_valid,  r_ex_wen,  r_ex_rd);
    assign w_b_mem = f_match(id_rt_used, id_rt, r_mem_valid, r_mem_wen, r_mem_rd);

    assign w_detect = w_id_live & (w_a_ex | w_b_ex) & r_ex_load;

    // Gated by rst_n so the stall is never asserted during a reset cycle.
    assign w_stall = rst_n & ((r_cnt != 2'd0) | (w_detect & (r_cnt == 2'd0)));

    // EX producer is the youngest and wins over MEM.
    always_comb begin
        w_a_fwd_nxt = 1'b0;
        w_a_mem_nxt = 1'b0;
        w_b_fwd_nxt = 1'b0;
        w_b_mem_nxt = 1'b0;
        if (w_id_live & ~w_stall) begin
            if (w_a_ex) begin
                w_a_fwd_nxt = 1'b1;
                w_a_mem_nxt = 1'b1;
            end else if (w_a_mem) begin
                w_a_fwd_nxt = 1'b1;
            end
            if (w_b_ex) begin
                w_b_fwd_nxt = 1'b1;
                w_b_mem_nxt = 1'b1;
            end else if (w_b_mem) begin
                w_b_fwd_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_wen    <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_wen   <= 1'b0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_rd    <= r_ex_rd;
            r_mem_wen   <= r_ex_wen;
            r_ex_valid  <= w_id_live & ~w_stall;
            r_ex_rd     <= id_rd;
            r_ex_wen    <= id_wen;
            r_ex_load   <= id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
        end else if (flush) begin
            r_cnt <= 2'd0;
        end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
        end else if (w_detect) begin
            r_cnt <= c_reload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_fwd      <= 1'b0;
            r_a_from_mem <= 1'b0;
            r_b_fwd      <= 1'b0;
            r_b_from_mem <= 1'b0;
        end else begin
            r_a_fwd      <= w_a_fwd_nxt;
            r_a_from_mem <= w_a_mem_nxt;
            r_b_fwd      <= w_b_fwd_nxt;
            r_b_from_mem <= w_b_mem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign a_fwd       = r_a_fwd;
    assign a_from_mem  = r_a_from_mem;
    assign b_fwd       = r_b_fwd;
    assign b_from_mem  = r_b_from_mem;
    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_ctrl
//  Brief    : Bench for fwd_hazard_ctrl with LOAD_STALL=1 and LOAD_STALL=3.
//  Revision : 1.0
// ============================================================================

module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt_rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_rs_used = 1'b0;
    logic        id_rt_used = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_wen = 1'b0;
    logic        id_is_load = 1'b0;
    logic        flush = 1'b0;

    logic [1:0]  d_stall;
    logic [1:0]  d_af;
    logic [1:0]  d_am;
    logic [1:0]  d_bf;
    logic [1:0]  d_bm;
    logic [31:0] cnt0;
    logic [31:0] cnt1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(d_stall[0]), .a_fwd(d_af[0]),
        .a_from_mem(d_am[0]), .b_fwd(d_bf[0]), .b_from_mem(d_bm[0]), .stall_count(cnt0)
    );

    fwd_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(d_stall[1]), .a_fwd(d_af[1]),
        .a_from_mem(d_am[1]), .b_fwd(d_bf[1]), .b_from_mem(d_bm[1]), .stall_count(cnt1)
    );

    // Reference model: a list of in-flight producers ordered by age (0 = youngest,
    // i.e. one instruction ahead of ID), plus a count of bubbles still owed.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       w;
        bit       ld;
    } prod_t;

    prod_t     m_fl   [2][2];
    int        m_left [2];
    bit [31:0] m_cnt  [2];
    bit        m_af   [2];
    bit        m_am   [2];
    bit        m_bf   [2];
    bit        m_bm   [2];

    function automatic int f_ls(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Age of the youngest in-flight producer of register r, or -1.
    function automatic int youngest(input int d, input bit used, input bit [4:0] r);
        if (!used || r == 5'd0) return -1;
        for (int a = 0; a < 2; a++)
            if (m_fl[d][a].v && m_fl[d][a].w && m_fl[d][a].rd == r) return a;
        return -1;
    endfunction

    function automatic bit m_hazard(input int d);
        int ya = youngest(d, id_rs_used, id_rs);
        int yb = youngest(d, id_rt_used, id_rt);
        return id_valid && !flush && (ya == 0 || yb == 0) && m_fl[d][0].ld;
    endfunction

    function automatic bit m_stall(input int d);
        return rst_n && (m_left[d] > 0 || m_hazard(d));
    endfunction

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            bit s  = m_stall(d);
            bit hz = m_hazard(d);
            int ya = youngest(d, id_rs_used, id_rs);
            int yb = youngest(d, id_rt_used, id_rt);
            if (!rst_n) begin
                m_left[d] = 0;
                m_cnt[d]  = 32'd0;
                m_af[d] = 1'b0; m_am[d] = 1'b0; m_bf[d] = 1'b0; m_bm[d] = 1'b0;
                m_fl[d][0].v = 1'b0;
                m_fl[d][1].v = 1'b0;
            end else begin
                if (s) m_cnt[d] = m_cnt[d] + 32'd1;
                if (flush)            m_left[d] = 0;
                else if (m_left[d] > 0) m_left[d] = m_left[d] - 1;
                else if (hz)          m_left[d] = f_ls(d) - 1;
                if (s || flush || !id_valid) begin
                    m_af[d] = 1'b0; m_am[d] = 1'b0; m_bf[d] = 1'b0; m_bm[d] = 1'b0;
                end else begin
                    m_af[d] = (ya >= 0); m_am[d] = (ya == 0);
                    m_bf[d] = (yb >= 0); m_bm[d] = (yb == 0);
                end
                m_fl[d][1]    = m_fl[d][0];
                m_fl[d][0].v  = id_valid && !flush && !s;
                m_fl[d][0].rd = id_rd;
                m_fl[d][0].w  = id_wen;
                m_fl[d][0].ld = id_is_load;
            end
        end
    endtask

    task automatic chk1(input string name, input int d, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d got %b expected %b at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_cnt[d] = 32'd0;
            m_af[d] = 1'b0; m_am[d] = 1'b0; m_bf[d] = 1'b0; m_bm[d] = 1'b0;
            for (int a = 0; a < 2; a++) begin
                m_fl[d][a].v = 1'b0; m_fl[d][a].rd = '0; m_fl[d][a].w = 1'b0; m_fl[d][a].ld = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            model_update();
        end
    end

    // Compare process: every output of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk1("stall", d, d_stall[d], m_stall(d));
                chk1("a_fwd", d, d_af[d], m_af[d]);
                chk1("a_from_mem", d, d_am[d], m_am[d]);
                chk1("b_fwd", d, d_bf[d], m_bf[d]);
                chk1("b_from_mem", d, d_bm[d], m_bm[d]);
            end
            chk32("stall_count", 0, cnt0, m_cnt[0]);
            chk32("stall_count", 1, cnt1, m_cnt[1]);
        end
    end

    task automatic drv(input bit v, input bit [4:0] rs, input bit ru, input bit [4:0] rt,
                       input bit tu, input bit [4:0] rd, input bit w, input bit ld, input bit fl);
        @(posedge clk);
        #1;
        rst_n      = nxt_rst;
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = ru;
        id_rt      = rt;
        id_rt_used = tu;
        id_rd      = rd;
        id_wen     = w;
        id_is_load = ld;
        flush      = fl;
        @(negedge clk);
    endtask

    task automatic nop();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drv_rand();
        drv(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        nxt_rst = 1'b0;
        repeat (2) nop();
        repeat (6) begin
            drv_rand();
            chk1("reset_stall", 0, d_stall[0], 1'b0);
            chk1("reset_stall", 1, d_stall[1], 1'b0);
        end
        chk32("reset_count", 0, cnt0, 32'd0);
        chk32("reset_count", 1, cnt1, 32'd0);

        nxt_rst = 1'b1;
        repeat (2) nop();

        // ALU r5 -> reader rs=5
        drv(1, 5'd1, 0, 5'd2, 0, 5'd5, 1, 0, 0);
        drv(1, 5'd5, 1, 5'd0, 0, 5'd10, 1, 0, 0);
        chk1("alu_nostall", 0, d_stall[0], 1'b0);
        nop();
        for (int d = 0; d < 2; d++) begin
            chk1("ex_a_fwd", d, d_af[d], 1'b1);
            chk1("ex_a_mem", d, d_am[d], 1'b1);
            chk1("ex_b_fwd", d, d_bf[d], 1'b0);
        end
        repeat (2) nop();

        // r5 writer, unrelated, reader rt=5
        drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
        drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 0);
        drv(1, 5'd0, 0, 5'd5, 1, 5'd11, 1, 0, 0);
        nop();
        chk1("mem_b_fwd", 0, d_bf[0], 1'b1);
        chk1("mem_b_mem", 0, d_bm[0], 1'b0);
        repeat (2) nop();

        // Two writers of r7, then reader rs=7
        drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
        drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
        drv(1, 5'd7, 1, 5'd0, 0, 5'd13, 1, 0, 0);
        nop();
        chk1("prio_a_fwd", 0, d_af[0], 1'b1);
        chk1("prio_a_mem", 0, d_am[0], 1'b1);
        repeat (2) nop();

        // Load r9 then reader rt=9 held in ID
        drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
        drv(1, 5'd0, 0, 5'd9, 1, 5'd12, 1, 0, 0);
        chk1("lu_stall_c1", 0, d_stall[0], 1'b1);
        chk1("lu_stall_c1", 1, d_stall[1], 1'b1);
        drv(1, 5'd0, 0, 5'd9, 1, 5'd12, 1, 0, 0);
        chk1("lu_stall_c2", 0, d_stall[0], 1'b0);
        chk1("lu_stall_c2", 1, d_stall[1], 1'b1);
        drv(1, 5'd0, 0, 5'd9, 1, 5'd12, 1, 0, 0);
        chk1("lu_stall_c3", 1, d_stall[1], 1'b1);
        chk1("lu_b_fwd", 0, d_bf[0], 1'b1);
        chk1("lu_b_mem", 0, d_bm[0], 1'b0);
        drv(1, 5'd0, 0, 5'd9, 1, 5'd12, 1, 0, 0);
        chk1("lu_stall_c4", 1, d_stall[1], 1'b0);
        nop();
        chk1("lu3_b_fwd", 1, d_bf[1], 1'b0);
        chk1("lu3_b_mem", 1, d_bm[1], 1'b0);
        chk32("lu_count", 0, cnt0, 32'd1);
        chk32("lu_count", 1, cnt1, 32'd3);
        repeat (2) nop();

        // r0 never forwards
        drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
        drv(1, 5'd0, 1, 5'd0, 0, 5'd14, 1, 0, 0);
        nop();
        chk1("r0_a_fwd", 0, d_af[0], 1'b0);
        repeat (2) nop();

        // Load-use together with flush
        drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
        drv(1, 5'd0, 0, 5'd9, 1, 5'd12, 1, 0, 1);
        chk1("flush_stall", 0, d_stall[0], 1'b0);
        chk1("flush_stall", 1, d_stall[1], 1'b0);
        nop();
        chk1("flush_b_fwd", 0, d_bf[0], 1'b0);
        chk32("flush_count", 0, cnt0, 32'd1);
        chk32("flush_count", 1, cnt1, 32'd3);

        repeat (3000) begin
            nxt_rst = ($urandom_range(0, 199) != 0);
            drv_rand();
        end
        nxt_rst = 1'b1;
        repeat (3) nop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
